// File: rtl/mip_pass_sched.sv
// mip_pass_sched
//
// Multi-pass scheduler for the morphological filter datapath. A sequence
// request (op + iteration count) is latched in IDLE. The scheduler then launches
// one filter pass at a time. Passes ping-pong between buf0 and buf1, and the
// first pass always reads ROM. The VGA display source only changes on a frame
// boundary, so the screen never shows a buffer that is being written.
//
// Optional feature macro: MIP_SCHED_WATCHDOG_EN
//   When this macro is defined, a per-pass watchdog aborts a pass that never
//   reports pass_done and sets the sticky err flag. When it is undefined, err
//   is tied low and WAIT blocks for as long as it takes.
//
// Parameters
//   TIMEOUT_W    watchdog counter width; a pass times out after 2^TIMEOUT_W-1 WAIT cycles
//
// Ports
//   clk          system clock (VGA_CTRL_CLK domain)
//   rst          synchronous active-high reset
//   pll_lock     clock valid; low aborts a running sequence and blocks new ones
//   start        sequence request, level-sampled in IDLE
//   op_sel       00 bypass, 01 erode, 10 dilate, 11 open (erode then dilate)
//   iters        repetitions per primitive (0 is treated as 1)
//   frame_sync   one-cycle pulse at the VGA frame boundary
//   pass_done    one-cycle pulse from the filter at the end of a pass
//   pass_start   one-cycle pass launch pulse
//   erosion_en   erosion active for the current pass
//   dilation_en  dilation active for the current pass
//   src_sel      pass source: 00 ROM, 01 buf0, 10 buf1
//   dst_buf      pass destination buffer (0 = buf0, 1 = buf1)
//   disp_sel     VGA source, same encoding as src_sel
//   pass_cnt     passes completed in the current/last sequence
//   busy         high in every state except IDLE
//   seq_done     one-cycle pulse on sequence completion
//   err          sticky watchdog error
module mip_pass_sched #(
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic [2:0] iters,
    input  logic       frame_sync,
    input  logic       pass_done,
    output logic       pass_start,
    output logic       erosion_en,
    output logic       dilation_en,
    output logic [1:0] src_sel,
    output logic       dst_buf,
    output logic [1:0] disp_sel,
    output logic [3:0] pass_cnt,
    output logic       busy,
    output logic       seq_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC_IN,
        S_ISSUE,
        S_WAIT,
        S_SYNC_OUT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [2:0] iters_q, iters_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic [3:0] iters_ext;
    logic [3:0] n_passes;
    logic [3:0] pass_cnt_inc;
    logic       in_pass;
    logic       wd_expire;

    assign iters_ext    = {1'b0, iters_q};
    assign pass_cnt_inc = pass_cnt_q + 4'd1;
    assign in_pass      = (state_q == S_ISSUE) || (state_q == S_WAIT);

    // Total passes for the latched op. iters_q is never 0, so open tops out at 14.
    always_comb begin
        n_passes = 4'd1;
        case (op_q)
            2'b01, 2'b10: n_passes = iters_ext;
            2'b11:        n_passes = {iters_q, 1'b0};
            default:      n_passes = 4'd1;
        endcase
    end

    // State and sequence registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            iters_q    <= 3'd0;
            pass_cnt_q <= 4'd0;
            disp_sel_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            iters_q    <= iters_d;
            pass_cnt_q <= pass_cnt_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    // Next-state logic. Losing pll_lock outranks every other event, so an
    // aborted sequence keeps pass_cnt and disp_sel exactly as they were.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        iters_d    = iters_q;
        pass_cnt_d = pass_cnt_q;
        disp_sel_d = disp_sel_q;
        if ((state_q != S_IDLE) && !pll_lock) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && pll_lock && !err) begin
                        op_d       = op_sel;
                        iters_d    = (iters == 3'd0) ? 3'd1 : iters;
                        pass_cnt_d = 4'd0;
                        state_d    = S_SYNC_IN;
                    end
                end
                S_SYNC_IN: begin
                    if (frame_sync) begin
                        disp_sel_d = 2'b00;
                        state_d    = S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    // When pass_done and frame_sync arrive together, pass_done
                    // wins. SYNC_OUT then needs a later frame boundary.
                    if (pass_done) begin
                        pass_cnt_d = pass_cnt_inc;
                        state_d    = (pass_cnt_inc == n_passes) ? S_SYNC_OUT : S_ISSUE;
                    end else if (wd_expire) begin
                        state_d = S_IDLE;
                    end
                end
                S_SYNC_OUT: begin
                    // An odd pass count ends in buf0 and an even count ends in buf1.
                    if (frame_sync) begin
                        disp_sel_d = n_passes[0] ? 2'b01 : 2'b10;
                        state_d    = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Per-pass routing is derived from the registered pass index k = pass_cnt_q.
    // Pass k writes buffer k[0] and reads the buffer written by pass k-1.
    always_comb begin
        erosion_en  = 1'b0;
        dilation_en = 1'b0;
        src_sel     = 2'b00;
        dst_buf     = 1'b0;
        if (in_pass) begin
            dst_buf = pass_cnt_q[0];
            if (pass_cnt_q != 4'd0) begin
                src_sel = pass_cnt_q[0] ? 2'b01 : 2'b10;
            end
            case (op_q)
                2'b01: erosion_en = 1'b1;
                2'b10: dilation_en = 1'b1;
                2'b11: begin
                    if (pass_cnt_q < iters_ext) begin
                        erosion_en = 1'b1;
                    end else begin
                        dilation_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIP_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 err_q, err_d;

    // The counter holds 0 on the first WAIT cycle. When the counter reads
    // 2^W-2, that cycle is WAIT cycle number 2^W-1, which is the last cycle allowed.
    assign wd_expire = (wd_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
    assign err       = err_q;

    // Watchdog: ISSUE always precedes WAIT, so the counter is cleared there.
    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (state_q == S_ISSUE) begin
            wd_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_d = wd_q + TIMEOUT_W'(1);
            if (pll_lock && !pass_done && wd_expire) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign wd_expire = 1'b0;

    // TIMEOUT_W only sizes the watchdog. Without the watchdog, nothing can raise err.
    if (TIMEOUT_W > 0) begin : g_no_watchdog
        assign err = 1'b0;
    end
`endif

    assign pass_start = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign seq_done   = (state_q == S_DONE);
    assign pass_cnt   = pass_cnt_q;
    assign disp_sel   = disp_sel_q;

endmodule
